// File: rtl/bcd_seq_to_binary.sv
// Digit-serial packed-BCD to binary converter with valid/ready handshakes.
// Consumes one digit per cycle, most significant first; flags illegal nibbles.
module bcd_seq_to_binary #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      binary,
    output logic                  err
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] sh_q, sh_d;
    logic                erracc_q, erracc_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                err_q, err_d;
    logic                ov_q, ov_d;

    logic [3:0]          digit;
    logic [BIN_W-1:0]    acc_n;
    logic                erracc_n;
    logic                last;

    assign digit    = sh_q[4*DIGITS-1 -: 4];
    assign acc_n    = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
    assign erracc_n = erracc_q | (digit > 4'd9);
    assign last     = (cnt_q == CW'(DIGITS - 1));

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = ov_q;
    assign binary    = bin_q;
    assign err       = err_q;

    // Next-state: capture in IDLE, multiply-accumulate in CONV, hold in DONE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        erracc_d = erracc_q;
        bin_d    = bin_q;
        err_d    = err_q;
        ov_d     = ov_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sh_d     = bcd;
                    acc_d    = '0;
                    cnt_d    = '0;
                    erracc_d = 1'b0;
                    state_d  = S_CONV;
                end
            end
            S_CONV: begin
                acc_d    = acc_n;
                erracc_d = erracc_n;
                sh_d     = sh_q << 4;
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    bin_d   = erracc_n ? '0 : acc_n;
                    err_d   = erracc_n;
                    ov_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ov_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            erracc_q <= 1'b0;
            bin_q    <= '0;
            err_q    <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            erracc_q <= erracc_d;
            bin_q    <= bin_d;
            err_q    <= err_d;
            ov_q     <= ov_d;
        end
    end

endmodule

// File: tb/tb_bcd_seq_to_binary.sv
// Directed bench for bcd_seq_to_binary: 4-digit and 1-digit instances.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_bcd_seq_to_binary;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] binary;
    logic        err;

    logic        i1_valid;
    logic        i1_ready;
    logic [3:0]  i1_bcd;
    logic        o1_valid;
    logic        o1_ready;
    logic [3:0]  o1_bin;
    logic        o1_err;

    int n_cmp;
    int n_bad;

    bcd_seq_to_binary #(.DIGITS(4), .BIN_W(14)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .bcd(bcd),
        .out_valid(out_valid), .out_ready(out_ready),
        .binary(binary), .err(err)
    );

    bcd_seq_to_binary #(.DIGITS(1), .BIN_W(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i1_valid), .in_ready(i1_ready), .bcd(i1_bcd),
        .out_valid(o1_valid), .out_ready(o1_ready),
        .binary(o1_bin), .err(o1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept4(input logic [15:0] v);
        bcd      = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait4(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) n = 99;
    endtask

    task automatic hs4();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            binary !== 14'd0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: rdy=%b ov=%b bin=%0d err=%b want 1 0 0 0",
                     in_ready, out_valid, binary, err);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        accept4(16'h1234);
        wait4(n);
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d want 4", n);
        end
        n_cmp++;
        if (binary !== 14'h04D2 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_1234: bin=%0d err=%b want 1234 0",
                     binary, err);
        end
        hs4();
    endtask

    task automatic test_back_to_back();
        int n;
        int bad_rdy;
        bad_rdy   = 0;
        out_ready = 1'b1;
        bcd       = 16'h9999;
        in_valid  = 1'b1;
        tick();
        bcd = 16'h0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k < 5 && in_ready !== 1'b0) bad_rdy++;
            if (k == 4) begin
                n_cmp++;
                if (out_valid !== 1'b1 || binary !== 14'h270F ||
                    err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_9999: ov=%b bin=%0d err=%b want 1 9999 0",
                             out_valid, binary, err);
                end
            end
        end
        n_cmp++;
        if (bad_rdy != 0) begin
            n_bad++;
            $display("FAIL b2b_ready_low: %0d cycles high want 0", bad_rdy);
        end
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: rdy=%b ov=%b want 1 0",
                     in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_second_accept: rdy=%b want 0", in_ready);
        end
        wait4(n);
        n_cmp++;
        if (n !== 4 || binary !== 14'd0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_zero: lat=%0d bin=%0d err=%b want 4 0 0",
                     n, binary, err);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        int n;
        accept4(16'h12A4);
        wait4(n);
        n_cmp++;
        if (n !== 4 || binary !== 14'd0 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_12A4: lat=%0d bin=%0d err=%b want 4 0 1",
                     n, binary, err);
        end
        hs4();
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        bad = 0;
        accept4(16'h0042);
        wait4(n);
        n_cmp++;
        if (n !== 4 || binary !== 14'd42 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_42: lat=%0d bin=%0d err=%b want 4 42 0",
                     n, binary, err);
        end
        bcd      = 16'h0007;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid !== 1'b1 || binary !== 14'd42 ||
                in_ready !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL bp_hold: %0d bad cycles want 0", bad);
        end
        hs4();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: ov=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        wait4(n);
        n_cmp++;
        if (n !== 4 || binary !== 14'd7 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_7: lat=%0d bin=%0d err=%b want 4 7 0",
                     n, binary, err);
        end
        hs4();
    endtask

    task automatic test_reset_mid_conv();
        int n;
        int seen;
        seen = 0;
        accept4(16'h5678);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || binary !== 14'd0 ||
            in_ready !== 1'b1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid: ov=%b bin=%0d rdy=%b err=%b want 0 0 1 0",
                     out_valid, binary, in_ready, err);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL rst_discard: ov high %0d cycles want 0", seen);
        end
        accept4(16'h0001);
        wait4(n);
        n_cmp++;
        if (n !== 4 || binary !== 14'd1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_after_1: lat=%0d bin=%0d err=%b want 4 1 0",
                     n, binary, err);
        end
        hs4();
    endtask

    task automatic test_digits1();
        int n;
        logic [3:0] vin [2];
        logic [3:0] vbin [2];
        logic       verr [2];
        vin[0] = 4'h4; vbin[0] = 4'd4; verr[0] = 1'b0;
        vin[1] = 4'hF; vbin[1] = 4'd0; verr[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            i1_bcd   = vin[t];
            i1_valid = 1'b1;
            tick();
            i1_valid = 1'b0;
            n = 0;
            do begin
                tick();
                n++;
            end while (!o1_valid && n < 10);
            n_cmp++;
            if (n !== 1 || o1_valid !== 1'b1 ||
                o1_bin !== vbin[t] || o1_err !== verr[t]) begin
                n_bad++;
                $display("FAIL d1_%0d: lat=%0d ov=%b bin=%0d err=%b want 1 1 %0d %b",
                         t, n, o1_valid, o1_bin, o1_err, vbin[t], verr[t]);
            end
            o1_ready = 1'b1;
            tick();
            o1_ready = 1'b0;
            n_cmp++;
            if (o1_valid !== 1'b0 || i1_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL d1_hs_%0d: ov=%b rdy=%b want 0 1",
                         t, o1_valid, i1_ready);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        in_valid  = 1'b0;
        bcd       = 16'h0;
        out_ready = 1'b0;
        i1_valid  = 1'b0;
        i1_bcd    = 4'h0;
        o1_ready  = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_reset_mid_conv();
        test_digits1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
